// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample generator: pattern modes, FSM states, LFSR taps.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_pkg;

  // Pattern selection, latched when the generator leaves IDLE.
  typedef enum logic [1:0] {
    MODE_RAMP    = 2'd0,
    MODE_IMPULSE = 2'd1,
    MODE_STEP    = 2'd2,
    MODE_LFSR    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  // x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register: bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/fir_sample_gen_if.sv
// Sample stream bundle between the generator and the FIR input.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready; a sample moves when both are high at a clock edge.
// Ports: out_sample (DATA_W), out_valid, out_ready.
interface fir_sample_gen_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] out_sample;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_sample, output out_valid, input out_ready);
  modport slave  (input out_sample, input out_valid, output out_ready);
endinterface

// File: rtl/fir_lfsr8.sv
// 8-bit Fibonacci LFSR, shifts left with feedback into bit 0.
// Latency: new state visible the cycle after load/adv.
// Backpressure: none; caller advances it only when a sample is consumed.
// Ports: clk, rst, load (reload SEED), adv (step once), state (current 8-bit value).
module fir_lfsr8
  import fir_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] state
);

  logic [7:0] state_q;
  logic [7:0] state_d;
  logic       fb;

  assign fb = ^(state_q & LFSR_TAPS);

  // load wins over adv so a restart always begins from the seed.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED;
    end else if (adv) begin
      state_d = {state_q[6:0], fb};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/fir_sample_gen.sv
// Paced pattern source (ramp/impulse/step/LFSR) feeding the FIR sample input.
// Latency: first out_valid PERIOD cycles after en is seen in IDLE; PERIOD+1 cycles per sample unstalled.
// Backpressure: sample held stable while out_ready=0; every stall cycle delays all later samples by one.
// Ports: clk, rst (async, active high), en (run level), mode (pattern, latched on start),
//        smp (out_sample/out_valid/out_ready), busy (not IDLE), sample_cnt (accepted samples).
module fir_sample_gen
  import fir_pkg::*;
#(
  parameter int         DATA_W    = 4,
  parameter int         PERIOD    = 8,
  parameter logic [7:0] LFSR_SEED = 8'h01,
  parameter int         CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  fir_sample_gen_if.master     smp,
  output logic                 busy,
  output logic [CNT_W-1:0]     sample_cnt
);

  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [PW-1:0]       pace_q, pace_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [DATA_W-1:0]   ramp_q, ramp_d;
  logic                first_q, first_d;   // high until the first sample of a run is accepted
  logic                lfsr_load;
  logic                lfsr_adv;
  logic [7:0]          lfsr_state;
  logic [DATA_W-1:0]   pat_val;
  logic                xfer;
  logic                unused_lfsr_hi;

  fir_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .adv   (lfsr_adv),
    .state (lfsr_state)
  );

  // Only the low DATA_W bits form a sample; the rest is internal LFSR state.
  assign unused_lfsr_hi = ^lfsr_state;

  always_comb begin
    pat_val = '0;
    case (mode_q)
      MODE_RAMP:    pat_val = ramp_q;
      MODE_IMPULSE: pat_val = {DATA_W{first_q}};
      MODE_STEP:    pat_val = '1;
      MODE_LFSR:    pat_val = lfsr_state[DATA_W-1:0];
      default:      pat_val = '0;
    endcase
  end

  assign xfer = (state_q == ST_PRESENT) && smp.out_ready;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    pace_d       = pace_q;
    sample_d     = sample_q;
    sample_cnt_d = sample_cnt_q;
    ramp_d       = ramp_q;
    first_d      = first_q;
    lfsr_load    = 1'b0;
    lfsr_adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          mode_d       = mode_e'(mode);
          sample_cnt_d = '0;
          pace_d       = PW'(PERIOD - 1);
          ramp_d       = '0;
          first_d      = 1'b1;
          lfsr_load    = 1'b1;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Dropping en here abandons the run before any sample is shown.
        if (!en) begin
          state_d = ST_IDLE;
        end else if (pace_q == '0) begin
          sample_d = pat_val;
          state_d  = ST_PRESENT;
        end else begin
          pace_d = pace_q - PW'(1);
        end
      end
      ST_PRESENT: begin
        // en is ignored until the pending sample is taken.
        if (xfer) begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
          ramp_d       = ramp_q + DATA_W'(1);
          first_d      = 1'b0;
          lfsr_adv     = 1'b1;
          pace_d       = PW'(PERIOD - 1);
          state_d      = en ? ST_WAIT : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_RAMP;
      pace_q       <= '0;
      sample_q     <= '0;
      sample_cnt_q <= '0;
      ramp_q       <= '0;
      first_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pace_q       <= pace_d;
      sample_q     <= sample_d;
      sample_cnt_q <= sample_cnt_d;
      ramp_q       <= ramp_d;
      first_q      <= first_d;
    end
  end

  assign smp.out_sample = sample_q;
  assign smp.out_valid  = (state_q == ST_PRESENT);
  assign busy           = (state_q != ST_IDLE);
  assign sample_cnt     = sample_cnt_q;

endmodule

// File: tb/tb_fir_sample_gen.sv
// Scoreboard bench for fir_sample_gen: stimulus queues expected samples, a monitor checks each transfer.
// Latency: n/a.
// Backpressure: bench drives out_ready, including a deliberate stall.
module tb_fir_sample_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        busy;
  logic [15:0] sample_cnt;

  fir_sample_gen_if #(.DATA_W(4)) sif ();

  fir_sample_gen #(
    .DATA_W    (4),
    .PERIOD    (8),
    .LFSR_SEED (8'h01),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .smp        (sif),
    .busy       (busy),
    .sample_cnt (sample_cnt)
  );

  typedef struct {
    int smp;
    int gap;   // expected cycles since previous transfer of the run; 0 = first of run
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mon_cnt  = 0;
  int   cyc      = 0;
  int   last_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int s, input int g);
    exp_t e;
    e.smp = s;
    e.gap = g;
    q.push_back(e);
  endtask

  // Monitor: a transfer is valid&ready seen mid-cycle; it completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && sif.out_valid && sif.out_ready) begin
      exp_t e;
      mon_cnt++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_xfer actual=%0d expected=none (t=%0t)", sif.out_sample, $time);
      end else begin
        e = q.pop_front();
        if (sif.out_sample !== 4'(e.smp)) begin
          failures++;
          $display("FAIL sample actual=%0d expected=%0d (t=%0t)", sif.out_sample, e.smp, $time);
        end
        if (e.gap != 0) chk("xfer_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  // Wait (bounded) until the monitor has seen target transfers; returns at negedge+1.
  task automatic wait_mon(input int target, input int budget);
    int i;
    i = 0;
    while (mon_cnt < target && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("xfer_count_reached", mon_cnt, target);
  endtask

  // Let n transfers happen, dropping en alongside the last one.
  task automatic finish_stream(input int base, input int n, input string nm);
    wait_mon(base + n, n * 40 + 50);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_cnt"}, sample_cnt, n);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_valid_after"}, sif.out_valid, 0);
  endtask

  task automatic run_stream(input int m, input int n, input string nm);
    int base;
    base = mon_cnt;
    mode = 2'(m);
    en   = 1'b1;
    finish_stream(base, n, nm);
  endtask

  initial begin
    int base;
    int n;
    int vcount;
    rst = 1'b1;
    en = 1'b0;
    mode = 2'd0;
    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_sample", sif.out_sample, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ramp: 0..15 then wrap to 0, one transfer every 9 cycles, en drops with the 17th.
    for (int k = 0; k < 17; k++) push(k % 16, (k == 0) ? 0 : 9);
    base = mon_cnt;
    mode = 2'd0;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("start_busy", busy, 1);
    chk("start_valid", sif.out_valid, 0);
    n = 0;
    while (!sif.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("first_valid_latency", n, 8);
    finish_stream(base, 17, "ramp");

    // Impulse.
    push(15, 0);
    for (int k = 1; k < 5; k++) push(0, 9);
    run_stream(1, 5, "impulse");

    // LFSR from seed 01: states 01,02,04,08,11.
    push(1, 0); push(2, 9); push(4, 9); push(8, 9); push(1, 9);
    run_stream(3, 5, "lfsr");

    // Step with a 5-cycle stall on the second sample.
    push(15, 0); push(15, 14); push(15, 9); push(15, 9);
    base = mon_cnt;
    mode = 2'd2;
    en = 1'b1;
    wait_mon(base + 1, 60);
    @(posedge clk);
    #1;
    sif.out_ready = 1'b0;
    n = 0;
    while (!sif.out_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_valid_seen", sif.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid_hold", sif.out_valid, 1);
      chk("stall_sample_hold", sif.out_sample, 15);
    end
    sif.out_ready = 1'b1;
    finish_stream(base, 4, "step");

    // en drops during WAIT: back to IDLE next cycle, nothing emitted.
    mode = 2'd0;
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("wait_busy", busy, 1);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("wait_abort_busy", busy, 0);
    chk("wait_abort_cnt", sample_cnt, 0);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (sif.out_valid) vcount++;
    end
    chk("wait_abort_no_valid", vcount, 0);

    // en drops in PRESENT with ready=1: exactly one transfer.
    push(0, 0);
    base = mon_cnt;
    en = 1'b1;
    n = 0;
    while (!sif.out_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("present_drop_busy", busy, 0);
    chk("present_drop_cnt", sample_cnt, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("present_drop_one_xfer", mon_cnt - base, 1);

    // Reset while a sample is pending, then restart from 0.
    push(0, 0); push(1, 9);
    base = mon_cnt;
    mode = 2'd0;
    en = 1'b1;
    wait_mon(base + 2, 80);
    @(posedge clk);
    #1;
    sif.out_ready = 1'b0;
    n = 0;
    while (!sif.out_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pre_rst_valid", sif.out_valid, 1);
    chk("pre_rst_cnt", sample_cnt, 2);
    rst = 1'b1;
    en = 1'b0;
    #1;
    chk("mid_rst_valid", sif.out_valid, 0);
    chk("mid_rst_cnt", sample_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sample", sif.out_sample, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    push(0, 0); push(1, 9); push(2, 9);
    run_stream(0, 3, "restart");

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_sample_gen.md
# fir_sample_gen

Hardware stimulus source driving the FIR filter's sample input. It produces a paced stream of DATA_W-bit samples in one of four patterns (ramp, impulse, step, pseudo-random), one sample every PERIOD cycles. Samples are delivered over a valid/ready handshake. It replaces bench-side stimulus so the filter can be exercised on silicon/FPGA and in self-contained regressions.

## Interface
Parameters:
- DATA_W, 4, sample width (≥2, ≤8)
- PERIOD, 8, cycles from acceptance (or start) to next out_valid (≥2)
- LFSR_SEED, 8'h01, initial LFSR state; must be non-zero
- CNT_W, 16, width of accepted-sample counter

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run request; level-sensitive
- mode  in  2  pattern: 0 ramp, 1 impulse, 2 step, 3 LFSR; sampled only when leaving IDLE
- out_sample  out  DATA_W  sample to FIR input `a`
- out_valid  out  1  out_sample holds a sample
- out_ready  in  1  consumer accepts; transfer = out_valid & out_ready at clk edge
- busy  out  1  FSM not in IDLE
- sample_cnt  out  CNT_W  accepted samples since start; wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, WAIT, PRESENT.
- IDLE: out_valid=0. If en=1: latch mode, clear sample_cnt, load pacing counter with PERIOD-1, reload pattern state, go WAIT.
- WAIT: pacing counter decrements each cycle; at 0 → PRESENT with out_valid=1 and out_sample = current pattern value.
- PRESENT: hold out_sample/out_valid until transfer. On transfer: advance pattern, sample_cnt+1, then en=1 → WAIT (counter reloaded to PERIOD-1); en=0 → IDLE.
- en deasserted in WAIT → IDLE next cycle, no sample emitted. en deasserted in PRESENT: pending sample still completes, then IDLE.
- Patterns (k = index of accepted sample, from 0):
  - ramp: k mod 2^DATA_W (wraps all-ones → 0)
  - impulse: k=0 all-ones; k≥1 zero
  - step: all-ones for every k
  - LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, feedback into bit0; output = state[DATA_W-1:0]; advance only on transfer
- mode changes while busy are ignored.
- All arithmetic unsigned; no saturation anywhere.

## Timing
- Reset values: out_sample=0, out_valid=0, busy=0, sample_cnt=0, LFSR=LFSR_SEED, state IDLE.
- Edge E samples en=1 in IDLE: busy=1 after E; out_valid rises after edge E+PERIOD.
- With out_ready tied 1: one transfer every PERIOD+1 cycles (PERIOD in WAIT/IDLE-exit, 1 in PRESENT).
- Back-pressure: each cycle of out_ready=0 in PRESENT delays all subsequent samples by one cycle; out_sample stable throughout.
- sample_cnt updates on the same edge as the transfer.
- rst mid-operation: all state returns to reset values immediately; any pending sample is discarded.
- Simultaneous transfer and en fall: transfer counts; next state IDLE.

## Structure
- Shared package fir_pkg: mode encodings (MODE_RAMP/IMPULSE/STEP/LFSR), FSM state typedef, LFSR tap mask constant.
- One sub-module: fir_lfsr8 (seed load, advance enable, 8-bit state out).
- Pacing counter, pattern mux and FSM live in the top.

## Test plan
- Reset, en=1 mode=0 ready=1, defaults → out_sample 0,1,2,…,15,0 with out_valid pulses 9 cycles apart; sample_cnt=17 after 17th transfer.
- mode=1, 5 transfers → samples 15,0,0,0,0.
- mode=3 seed 8'h01 → first LFSR states 01,02,04,08,11 → samples 1,2,4,8,1.
- mode=2, hold ready=0 for 5 cycles on 2nd sample → out_sample stays 15, valid stays 1, 3rd valid 5 cycles later than unstalled.
- en drops during WAIT → no valid, IDLE next cycle; en drops in PRESENT with ready=1 → exactly one transfer, then busy=0.
- rst pulsed in PRESENT → out_valid=0, sample_cnt=0 immediately; restart ramp begins at 0.
